irq_request_latch: RTL and testbench

Request front-end for the 4-input priority encoder. Captures four request lines into a sticky pending register and drives the masked pending vector into the encoder. Takes the encoder's `out`/`valid` back and presents one registered interrupt (`irq`, `irq_id`) to the consumer under a hold-until-ack handshake. Clears the serviced pending bit on acknowledge.

---
 rtl/irq_request_latch_if.sv | 38 +++
 rtl/irq_request_latch.sv | 96 +++++++++
 tb/tb_irq_request_latch.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/irq_request_latch_if.sv
// Request/encoder/consumer signal bundle for irq_request_latch.
interface irq_request_latch_if;
    logic [3:0] req;        // raw request lines
    logic [3:0] mask;       // per-line enable toward the encoder
    logic [3:0] pend_vec;   // pending & mask, feeds encoder input
    logic [1:0] enc_out;    // encoder index of highest set bit
    logic       enc_valid;  // encoder valid (pend_vec != 0)
    logic       irq;        // registered interrupt toward consumer
    logic [1:0] irq_id;     // registered line index being signalled
    logic       ack;        // consumer acknowledge
    logic [3:0] pending;    // raw pending status

    // Environment side: request sources, encoder and consumer.
    modport master (
        output req,
        output mask,
        input  pend_vec,
        output enc_out,
        output enc_valid,
        input  irq,
        input  irq_id,
        output ack,
        input  pending
    );

    // Latch side.
    modport slave (
        input  req,
        input  mask,
        output pend_vec,
        input  enc_out,
        input  enc_valid,
        output irq,
        output irq_id,
        input  ack,
        output pending
    );
endinterface

// File: rtl/irq_request_latch.sv
// Sticky request latch in front of a 4-input priority encoder, presenting one
// interrupt at a time to the consumer with a hold-until-ack handshake.
module irq_request_latch #(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    irq_request_latch_if.slave   bus
);

    localparam int unsigned N_LINES = 4;
    localparam int unsigned ID_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e              state_q,   state_d;
    logic [N_LINES-1:0]  req_d_q,   req_d_d;
    logic [N_LINES-1:0]  pending_q, pending_d;
    logic                irq_q,     irq_d;
    logic [ID_W-1:0]     irq_id_q,  irq_id_d;

    logic [N_LINES-1:0]  set_vec;
    logic [N_LINES-1:0]  clr_vec;
    logic                ack_acc;

    // Request capture and pending update; set beats clear so no request is lost.
    always_comb begin
        req_d_d   = bus.req;
        set_vec   = EDGE_MODE ? (bus.req & ~req_d_q) : bus.req;
        ack_acc   = (state_q == ST_ARMED) && bus.ack;
        clr_vec   = '0;
        if (ack_acc) begin
            clr_vec[irq_id_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr_vec) | set_vec;
    end

    // Handshake FSM: priority is sampled only in IDLE, held until ack, then one gap cycle.
    always_comb begin
        state_d  = state_q;
        irq_d    = irq_q;
        irq_id_d = irq_id_q;
        case (state_q)
            ST_IDLE: begin
                irq_d = 1'b0;
                if (bus.enc_valid) begin
                    state_d  = ST_ARMED;
                    irq_d    = 1'b1;
                    irq_id_d = bus.enc_out;
                end
            end
            ST_ARMED: begin
                if (ack_acc) begin
                    state_d = ST_GAP;
                    irq_d   = 1'b0;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            req_d_q   <= '0;
            pending_q <= '0;
            irq_q     <= 1'b0;
            irq_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            req_d_q   <= req_d_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
            irq_id_q  <= irq_id_d;
        end
    end

    // Output drive: only pend_vec is combinational, into the encoder.
    assign bus.pend_vec = pending_q & bus.mask;
    assign bus.pending  = pending_q;
    assign bus.irq      = irq_q;
    assign bus.irq_id   = irq_id_q;

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed self-checking bench for irq_request_latch (edge and level instances).
module tb_irq_request_latch;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    irq_request_latch_if bus_e ();
    irq_request_latch_if bus_l ();

    irq_request_latch #(.EDGE_MODE(1'b1)) u_edge (.clk(clk), .rst_n(rst_n), .bus(bus_e));
    irq_request_latch #(.EDGE_MODE(1'b0)) u_lvl  (.clk(clk), .rst_n(rst_n), .bus(bus_l));

    // External 4-input priority encoder.
    function automatic logic [1:0] enc_idx(input logic [3:0] v);
        if (v[3])      return 2'd3;
        else if (v[2]) return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    assign bus_e.enc_out   = enc_idx(bus_e.pend_vec);
    assign bus_e.enc_valid = |bus_e.pend_vec;
    assign bus_l.enc_out   = enc_idx(bus_l.pend_vec);
    assign bus_l.enc_valid = |bus_l.pend_vec;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (bus_e.pending !== 4'b0000) begin bad++; $display("FAIL reset_pending got=%b exp=0000", bus_e.pending); end
        total++; if (bus_e.irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", bus_e.irq); end
        total++; if (bus_e.irq_id !== 2'd0) begin bad++; $display("FAIL reset_irq_id got=%0d exp=0", bus_e.irq_id); end
        total++; if (bus_e.pend_vec !== 4'b0000) begin bad++; $display("FAIL reset_pend_vec got=%b exp=0000", bus_e.pend_vec); end
        total++; if (bus_l.pending !== 4'b0000 || bus_l.irq !== 1'b0) begin bad++; $display("FAIL reset_lvl got=%b/%b exp=0000/0", bus_l.pending, bus_l.irq); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus_e.req = 4'b0100;
        tick(); // E0
        total++; if (bus_e.pending !== 4'b0100) begin bad++; $display("FAIL single_pend_e0 got=%b exp=0100", bus_e.pending); end
        total++; if (bus_e.pend_vec !== 4'b0100) begin bad++; $display("FAIL single_vec_e0 got=%b exp=0100", bus_e.pend_vec); end
        total++; if (bus_e.irq !== 1'b0) begin bad++; $display("FAIL single_irq_e0 got=%b exp=0", bus_e.irq); end
        tick(); // E1
        total++; if (bus_e.irq !== 1'b1 || bus_e.irq_id !== 2'd2) begin bad++; $display("FAIL single_irq_e1 got=%b/%0d exp=1/2", bus_e.irq, bus_e.irq_id); end
        tick(); // E2
        total++; if (bus_e.irq !== 1'b1 || bus_e.irq_id !== 2'd2) begin bad++; $display("FAIL single_hold_e2 got=%b/%0d exp=1/2", bus_e.irq, bus_e.irq_id); end
        bus_e.ack = 1'b1;
        tick(); // E3
        bus_e.ack = 1'b0;
        total++; if (bus_e.irq !== 1'b0 || bus_e.pending !== 4'b0000) begin bad++; $display("FAIL single_ack got=%b/%b exp=0/0000", bus_e.irq, bus_e.pending); end
        bus_e.req = 4'b0000;
        tick();
        tick();
        total++; if (bus_e.irq !== 1'b0) begin bad++; $display("FAIL single_quiet got=%b exp=0", bus_e.irq); end
    endtask

    task automatic test_priority();
        logic [1:0] ids  [3];
        logic [3:0] pend [3];
        ids  = '{2'd3, 2'd1, 2'd0};
        pend = '{4'b0011, 4'b0001, 4'b0000};
        bus_e.req = 4'b1011;
        tick();
        total++; if (bus_e.pending !== 4'b1011) begin bad++; $display("FAIL prio_pend got=%b exp=1011", bus_e.pending); end
        bus_e.req = 4'b0000;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++; if (bus_e.irq !== 1'b1 || bus_e.irq_id !== ids[i]) begin bad++; $display("FAIL prio_id%0d got=%b/%0d exp=1/%0d", i, bus_e.irq, bus_e.irq_id, ids[i]); end
            bus_e.ack = 1'b1;
            tick();
            bus_e.ack = 1'b0;
            total++; if (bus_e.irq !== 1'b0 || bus_e.pending !== pend[i]) begin bad++; $display("FAIL prio_ack%0d got=%b/%b exp=0/%b", i, bus_e.irq, bus_e.pending, pend[i]); end
            tick();
            total++; if (bus_e.irq !== 1'b0) begin bad++; $display("FAIL prio_gap%0d got=%b exp=0", i, bus_e.irq); end
            tick();
        end
        total++; if (bus_e.irq !== 1'b0 || bus_e.pending !== 4'b0000) begin bad++; $display("FAIL prio_end got=%b/%b exp=0/0000", bus_e.irq, bus_e.pending); end
    endtask

    task automatic test_mask();
        bus_e.mask = 4'b1110;
        bus_e.req  = 4'b0001;
        tick();
        total++; if (bus_e.pending !== 4'b0001 || bus_e.pend_vec !== 4'b0000) begin bad++; $display("FAIL mask_hide got=%b/%b exp=0001/0000", bus_e.pending, bus_e.pend_vec); end
        tick();
        tick();
        total++; if (bus_e.irq !== 1'b0) begin bad++; $display("FAIL mask_noirq got=%b exp=0", bus_e.irq); end
        bus_e.mask = 4'b1111;
        tick();
        total++; if (bus_e.irq !== 1'b1 || bus_e.irq_id !== 2'd0) begin bad++; $display("FAIL mask_unmask got=%b/%0d exp=1/0", bus_e.irq, bus_e.irq_id); end
        bus_e.req = 4'b1001;
        tick();
        total++; if (bus_e.pending !== 4'b1001 || bus_e.irq_id !== 2'd0) begin bad++; $display("FAIL mask_noretract got=%b/%0d exp=1001/0", bus_e.pending, bus_e.irq_id); end
        tick();
        total++; if (bus_e.irq !== 1'b1 || bus_e.irq_id !== 2'd0) begin bad++; $display("FAIL mask_hold got=%b/%0d exp=1/0", bus_e.irq, bus_e.irq_id); end
        bus_e.ack = 1'b1;
        tick();
        bus_e.ack = 1'b0;
        total++; if (bus_e.irq !== 1'b0 || bus_e.pending !== 4'b1000) begin bad++; $display("FAIL mask_ack0 got=%b/%b exp=0/1000", bus_e.irq, bus_e.pending); end
        tick();
        tick();
        total++; if (bus_e.irq !== 1'b1 || bus_e.irq_id !== 2'd3) begin bad++; $display("FAIL mask_next got=%b/%0d exp=1/3", bus_e.irq, bus_e.irq_id); end
        bus_e.mask = 4'b0111;
        tick();
        total++; if (bus_e.irq !== 1'b1 || bus_e.irq_id !== 2'd3 || bus_e.pend_vec !== 4'b0000) begin bad++; $display("FAIL mask_drop got=%b/%0d/%b exp=1/3/0000", bus_e.irq, bus_e.irq_id, bus_e.pend_vec); end
        bus_e.ack = 1'b1;
        tick();
        bus_e.ack  = 1'b0;
        bus_e.mask = 4'b1111;
        bus_e.req  = 4'b0000;
        total++; if (bus_e.pending !== 4'b0000) begin bad++; $display("FAIL mask_clean got=%b exp=0000", bus_e.pending); end
        tick();
        tick();
    endtask

    task automatic test_collision();
        bus_e.req = 4'b0100;
        tick();
        tick();
        total++; if (bus_e.irq !== 1'b1 || bus_e.irq_id !== 2'd2) begin bad++; $display("FAIL coll_armed got=%b/%0d exp=1/2", bus_e.irq, bus_e.irq_id); end
        bus_e.req = 4'b0000;
        tick();
        bus_e.req = 4'b0100;
        bus_e.ack = 1'b1;
        tick();
        bus_e.ack = 1'b0;
        total++; if (bus_e.pending !== 4'b0100 || bus_e.irq !== 1'b0) begin bad++; $display("FAIL coll_setwins got=%b/%b exp=0100/0", bus_e.pending, bus_e.irq); end
        tick();
        total++; if (bus_e.irq !== 1'b0) begin bad++; $display("FAIL coll_gap got=%b exp=0", bus_e.irq); end
        tick();
        total++; if (bus_e.irq !== 1'b1 || bus_e.irq_id !== 2'd2) begin bad++; $display("FAIL coll_resig got=%b/%0d exp=1/2", bus_e.irq, bus_e.irq_id); end
        bus_e.ack = 1'b1;
        tick();
        bus_e.ack = 1'b0;
        bus_e.req = 4'b0000;
        tick();
        tick();
        total++; if (bus_e.pending !== 4'b0000 || bus_e.irq !== 1'b0) begin bad++; $display("FAIL coll_clean got=%b/%b exp=0000/0", bus_e.pending, bus_e.irq); end
    endtask

    task automatic test_level();
        bus_l.mask = 4'b1111;
        bus_l.req  = 4'b0010;
        tick();
        total++; if (bus_l.pending !== 4'b0010) begin bad++; $display("FAIL lvl_pend got=%b exp=0010", bus_l.pending); end
        tick();
        for (int i = 0; i < 2; i++) begin
            total++; if (bus_l.irq !== 1'b1 || bus_l.irq_id !== 2'd1) begin bad++; $display("FAIL lvl_irq%0d got=%b/%0d exp=1/1", i, bus_l.irq, bus_l.irq_id); end
            bus_l.ack = 1'b1;
            tick();
            bus_l.ack = 1'b0;
            total++; if (bus_l.irq !== 1'b0 || bus_l.pending !== 4'b0010) begin bad++; $display("FAIL lvl_reset%0d got=%b/%b exp=0/0010", i, bus_l.irq, bus_l.pending); end
            tick();
            tick();
        end
        total++; if (bus_l.irq !== 1'b1 || bus_l.irq_id !== 2'd1) begin bad++; $display("FAIL lvl_irq2 got=%b/%0d exp=1/1", bus_l.irq, bus_l.irq_id); end
        bus_l.req = 4'b0000;
        tick();
        total++; if (bus_l.pending !== 4'b0010 || bus_l.irq !== 1'b1) begin bad++; $display("FAIL lvl_sticky got=%b/%b exp=0010/1", bus_l.pending, bus_l.irq); end
        bus_l.ack = 1'b1;
        tick();
        bus_l.ack = 1'b0;
        total++; if (bus_l.pending !== 4'b0000 || bus_l.irq !== 1'b0) begin bad++; $display("FAIL lvl_clear got=%b/%b exp=0000/0", bus_l.pending, bus_l.irq); end
        tick();
        tick();
        tick();
        total++; if (bus_l.irq !== 1'b0) begin bad++; $display("FAIL lvl_quiet got=%b exp=0", bus_l.irq); end
    endtask

    task automatic test_reset_mid();
        bus_e.req = 4'b0110;
        tick();
        tick();
        total++; if (bus_e.irq !== 1'b1 || bus_e.irq_id !== 2'd2 || bus_e.pending !== 4'b0110) begin bad++; $display("FAIL rmid_armed got=%b/%0d/%b exp=1/2/0110", bus_e.irq, bus_e.irq_id, bus_e.pending); end
        bus_e.req = 4'b0100;
        rst_n     = 1'b0;
        bus_e.ack = 1'b1;
        tick();
        rst_n     = 1'b1;
        bus_e.ack = 1'b0;
        total++; if (bus_e.irq !== 1'b0 || bus_e.irq_id !== 2'd0 || bus_e.pending !== 4'b0000 || bus_e.pend_vec !== 4'b0000) begin bad++; $display("FAIL rmid_reset got=%b/%0d/%b/%b exp=0/0/0000/0000", bus_e.irq, bus_e.irq_id, bus_e.pending, bus_e.pend_vec); end
        tick();
        total++; if (bus_e.pending !== 4'b0100 || bus_e.irq !== 1'b0) begin bad++; $display("FAIL rmid_held got=%b/%b exp=0100/0", bus_e.pending, bus_e.irq); end
        tick();
        total++; if (bus_e.irq !== 1'b1 || bus_e.irq_id !== 2'd2) begin bad++; $display("FAIL rmid_irq got=%b/%0d exp=1/2", bus_e.irq, bus_e.irq_id); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        bus_e.req  = 4'b0000;
        bus_e.mask = 4'b1111;
        bus_e.ack  = 1'b0;
        bus_l.req  = 4'b0000;
        bus_l.mask = 4'b1111;
        bus_l.ack  = 1'b0;
        #2;
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_collision();
        test_level();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
